instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly downstream of program_counter. Takes the current PC, issues in-order requests to
//  instruction memory, buffers returned instructions with their PC, and hands them to decode via valid/ready.
//  Sole driver of the PC's write_back/jump/jump_location inputs: advances the PC per accepted request and
//  applies redirects. Discards responses that were in flight when a redirect arrived.
// PARAMETERS
//  QUEUE_DEPTH  3  entries in fetch queue; also caps outstanding requests (>=3 gives 1 instr/cycle at 1-cycle memory)
// PORTS
//  clock          in   1   system clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  fetch_addr     in   32  word_address; PC next_instruction_addr
//  pc_write_back  out  1   to PC write_back
//  pc_jump        out  1   to PC jump
//  pc_jump_loc    out  32  to PC jump_location
//  redirect_valid in   1   taken branch/jump resolved downstream
//  redirect_addr  in   32  redirect target
//  imem_req       out  1   memory request valid
//  imem_addr      out  32  request address (= fetch_addr)
//  imem_ready     in   1   memory accepts request this cycle
//  imem_rvalid    in   1   response valid; responses in request order, latency >= 1 cycle
//  imem_rdata     in   32  instruction word
//  if_valid       out  1   queue head valid to decode
//  if_instr       out  32  queue head instruction
//  if_pc          out  32  queue head PC
//  if_ready       in   1   decode consumes head this cycle
// BEHAVIOUR
//  - Reset: queue empty, outstanding=0, drop_count=0; outputs if_valid=0, imem_req=0, pc_write_back=0,
//    pc_jump=0, pc_jump_loc=0. Reset mid-transfer abandons all in-flight state; later rvalid ignored while drop_count=0? no:
//    memory is reset by the same reset, so no post-reset responses expected.
//  - Credit: imem_req=1 iff !redirect_valid && (outstanding + count + drop_count) < QUEUE_DEPTH.
//  - Issue: imem_req && imem_ready -> pc_write_back=1, pc_jump=0 same cycle (PC steps +4 at edge);
//    outstanding++, and fetch_addr pushed to an in-order pc-tag FIFO (depth QUEUE_DEPTH).
//  - Response: imem_rvalid with drop_count>0 -> drop_count--, tag popped, nothing enqueued. Otherwise outstanding--,
//    {imem_rdata, tag} enqueued; visible on if_valid next cycle (no bypass; registered output).
//  - Dequeue: if_valid && if_ready pops head. Push and pop same cycle allowed at any count, including full.
//  - Redirect (highest priority): pc_write_back=1, pc_jump=1, pc_jump_loc=redirect_addr; imem_req=0; queue
//    flushed (if_valid=0 next cycle); drop_count <= drop_count + outstanding (after this cycle's response); outstanding<=0.
//    Response arriving in the redirect cycle is stale and dropped. Simultaneous if_ready pop is moot (flushed).
//    Issue resumes the cycle after redirect from the new PC.
//  - Back-to-back redirects: each overrides; drop_count accumulates, never exceeds QUEUE_DEPTH.
//  - Counters: outstanding, count, drop_count are $clog2(QUEUE_DEPTH+1) bits; overflow/underflow impossible by
//    credit rule; assertions fire on rvalid with outstanding+drop_count==0.
//  - Addresses pass unmodified; alignment of redirect_addr is the producer's responsibility.
// STRUCTURE
//  - Shared definitions header: word_address, instruction_word typedef, BOOT_ADDRESS, INSTR_BYTES (=4).
//  - Sub-module fetch_queue: parameterised sync FIFO (DATA_WIDTH, DEPTH) with push/pop/flush/count/full/empty;
//    instantiated twice (pc-tag FIFO, instruction queue). Top holds credit, drop and PC-control logic.
// TESTING
//  - Reset, 1-cycle memory, if_ready=1: if_pc = BOOT_ADDRESS, +4, +8... one per cycle after 3-cycle fill; pc_write_back every cycle.
//  - if_ready=0: exactly 3 requests issued, imem_req=0 thereafter; release -> 3 instrs in order, fetch resumes.
//  - 2 requests outstanding at 3-cycle latency, redirect to 0x0000_0100: both responses dropped, next if_pc=0x100.
//  - Redirect in same cycle as imem_rvalid and if_ready: response dropped, queue empty, pc_jump=1, imem_req=0.
//  - imem_ready held 0 for 5 cycles: imem_addr stable, pc_write_back=0 throughout, PC unchanged.
//  - Reset asserted with queue full and 2 outstanding: next cycle all outputs at reset values, fetch restarts at BOOT_ADDRESS.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: address/instruction types, boot vector and the
// record stored in the instruction queue.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word_address;
  typedef logic [31:0] instruction_word;

  localparam word_address BOOT_ADDRESS = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES  = 4;

  typedef struct packed {
    instruction_word instr;
    word_address     pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO with registered storage; push and pop may coincide at
// any occupancy, flush empties it in one cycle.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [DATA_WIDTH-1:0]      i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DATA_WIDTH-1:0]      o_head_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  // A pop frees the head slot, so a push into a full queue is legal alongside it.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order instruction memory requests from the PC, tags them,
// queues returned words for decode and steers the PC (step or redirect).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  word_address     fetch_addr,
  output logic            pc_write_back,
  output logic            pc_jump,
  output word_address     pc_jump_loc,
  input  logic            redirect_valid,
  input  word_address     redirect_addr,
  output logic            imem_req,
  output word_address     imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  instruction_word imem_rdata,
  output logic            if_valid,
  output instruction_word if_instr,
  output word_address     if_pc,
  input  logic            if_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_count;
  logic [CW-1:0]   w_q_count;
  logic [CW-1:0]   w_tag_count;
  logic [CW+1:0]   w_inflight;
  logic            w_issue;
  logic            w_drop_rsp;
  logic            w_rsp_live;
  logic            w_accept_rsp;
  logic            w_q_full;
  logic            w_q_empty;
  logic            w_tag_full;
  logic            w_tag_empty;
  word_address     w_tag_head;
  fetch_entry_t    w_q_in;
  fetch_entry_t    w_q_head;

  // Every slot a response could land in is reserved up front: queued, in flight, or to be dropped.
  assign w_inflight = {2'b00, r_outstanding} + {2'b00, w_q_count} + {2'b00, r_drop_count};

  assign imem_req      = !reset && !redirect_valid && (w_inflight < (CW+2)'(QUEUE_DEPTH));
  assign imem_addr     = fetch_addr;
  assign w_issue       = imem_req && imem_ready;
  assign pc_jump       = !reset && redirect_valid;
  assign pc_write_back = w_issue || pc_jump;
  assign pc_jump_loc   = pc_jump ? redirect_addr : '0;

  assign w_drop_rsp   = imem_rvalid && (r_drop_count != '0);
  assign w_rsp_live   = imem_rvalid && !w_drop_rsp;
  assign w_accept_rsp = w_rsp_live && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_outstanding <= '0;
      r_drop_count  <= '0;
    end else if (redirect_valid) begin
      r_outstanding <= '0;
      r_drop_count  <= r_drop_count + r_outstanding - CW'(imem_rvalid);
    end else begin
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp_live);
      if (w_drop_rsp) r_drop_count <= r_drop_count - CW'(1);
    end
  end

  // Tags survive redirects so that stale responses still retire their own entry.
  fetch_queue #(
    .DATA_WIDTH ($bits(word_address)),
    .DEPTH      (QUEUE_DEPTH)
  ) u_tag_fifo (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_issue),
    .i_push_data (fetch_addr),
    .i_pop       (imem_rvalid),
    .i_flush     (1'b0),
    .o_head_data (w_tag_head),
    .o_count     (w_tag_count),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

  assign w_q_in = '{instr: imem_rdata, pc: w_tag_head};

  fetch_queue #(
    .DATA_WIDTH ($bits(fetch_entry_t)),
    .DEPTH      (QUEUE_DEPTH)
  ) u_instr_queue (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_accept_rsp),
    .i_push_data (w_q_in),
    .i_pop       (if_ready),
    .i_flush     (redirect_valid),
    .o_head_data (w_q_head),
    .o_count     (w_q_count),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty)
  );

  assign if_valid = !w_q_empty;
  assign if_instr = w_q_head.instr;
  assign if_pc    = w_q_head.pc;

  a_rsp_expected: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> ((r_outstanding != '0) || (r_drop_count != '0)) && !w_tag_empty);
  a_tag_tracks: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, w_tag_count} == ({1'b0, r_outstanding} + {1'b0, r_drop_count})));
  a_no_tag_overflow: assert property (@(posedge clock) disable iff (reset)
    w_issue |-> !w_tag_full);
  a_no_queue_overflow: assert property (@(posedge clock) disable iff (reset)
    w_accept_rsp |-> (!w_q_full || if_ready));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: constant vectors, directed corner sequences and
// randomized traffic against an epoch-tagged memory / decode-queue reference model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int DEPTH = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        pc_write_back, pc_jump;
  logic [31:0] pc_jump_loc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        if_ready = 1'b0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_addr     (fetch_addr),
    .pc_write_back  (pc_write_back),
    .pc_jump        (pc_jump),
    .pc_jump_loc    (pc_jump_loc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  // Reference model: PC register, in-order memory with per-request due cycle and
  // redirect epoch, and the list of PCs decode should currently see.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] dq[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat = 1;
  logic [31:0] pc_m = BOOT_ADDRESS;
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;

  logic        o_valid, o_req, o_wb, o_jump, o_consumed;
  logic [31:0] o_pc, o_addr;

  typedef struct {
    logic        redir;
    logic [31:0] raddr;
    logic        mrdy;
    logic [31:0] faddr;
    logic        exp_req;
    logic        exp_wb;
    logic        exp_jump;
    logic [31:0] exp_loc;
  } vec_t;

  vec_t vt[4];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic step(input logic mrdy, input logic drdy, input logic redir,
                      input logic [31:0] raddr);
    logic        resp, exp_req, issue, exp_valid;
    mreq_t       r;
    @(negedge clock);
    reset          = 1'b0;
    fetch_addr     = pc_m;
    imem_ready     = mrdy;
    if_ready       = drdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    resp           = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid    = resp;
    imem_rdata     = resp ? instr_of(mq[0].addr) : $urandom();
    #1;
    exp_req   = !redir && ((mq.size() + dq.size()) < DEPTH);
    issue     = exp_req && mrdy;
    exp_valid = (dq.size() > 0);
    chk1("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, pc_m);
    chk1("pc_write_back", pc_write_back, issue || redir);
    chk1("pc_jump", pc_jump, redir);
    chk("pc_jump_loc", pc_jump_loc, redir ? raddr : 32'h0);
    chk1("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      chk("if_pc", if_pc, dq[0]);
      chk("if_instr", if_instr, instr_of(dq[0]));
    end
    o_valid    = if_valid;
    o_req      = imem_req;
    o_wb       = pc_write_back;
    o_jump     = pc_jump;
    o_pc       = if_pc;
    o_addr     = imem_addr;
    o_consumed = exp_valid && drdy && !redir;
    if (issue) issued++;
    @(posedge clock);
    if (o_consumed) void'(dq.pop_front());
    if (resp) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !redir) dq.push_back(r.addr);
    end
    if (redir) begin
      dq.delete();
      epoch++;
      pc_m = raddr;
    end else if (issue) begin
      r.addr  = pc_m;
      r.due   = cyc + lat;
      r.epoch = epoch;
      mq.push_back(r);
      pc_m = pc_m + 32'(INSTR_BYTES);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    imem_ready     = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    fetch_addr     = pc_m;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk1("rst if_valid", if_valid, 1'b0);
    chk1("rst imem_req", imem_req, 1'b0);
    chk1("rst pc_write_back", pc_write_back, 1'b0);
    chk1("rst pc_jump", pc_jump, 1'b0);
    chk("rst pc_jump_loc", pc_jump_loc, 32'h0);
    @(posedge clock);
    mq.delete();
    dq.delete();
    pc_m   = BOOT_ADDRESS;
    epoch++;
    issued = 0;
  endtask

  initial begin
    logic        found, seen_req;
    logic [31:0] first_pc, hold;
    int          ncons;

    // Empty-state combinational behaviour straight out of reset.
    vt[0] = '{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'h0000_0100};
    vt[3] = '{1'b1, 32'hDEAD_BEEC, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEC};

    foreach (vt[k]) begin
      do_reset();
      @(negedge clock);
      reset          = 1'b0;
      fetch_addr     = vt[k].faddr;
      imem_ready     = vt[k].mrdy;
      redirect_valid = vt[k].redir;
      redirect_addr  = vt[k].raddr;
      imem_rvalid    = 1'b0;
      if_ready       = 1'b1;
      #1;
      chk1("vec imem_req", imem_req, vt[k].exp_req);
      chk1("vec pc_write_back", pc_write_back, vt[k].exp_wb);
      chk1("vec pc_jump", pc_jump, vt[k].exp_jump);
      chk("vec pc_jump_loc", pc_jump_loc, vt[k].exp_loc);
      chk("vec imem_addr", imem_addr, vt[k].faddr);
      chk1("vec if_valid", if_valid, 1'b0);
      @(posedge clock);
      @(negedge clock);
      #1;
      chk1("vec if_valid next", if_valid, 1'b0);
    end

    // Streaming at 1-cycle memory latency with decode always ready.
    do_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk1("fill wb", o_wb, 1'b1);
      chk1("fill valid", o_valid, i >= 2);
      if (i >= 2) chk("fill pc", o_pc, BOOT_ADDRESS + 32'(4 * (i - 2)));
    end

    // Decode stalled: credit caps issue at the queue depth.
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall issued", 32'(issued), 32'd3);
    chk1("stall req", o_req, 1'b0);
    ncons    = 0;
    seen_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_consumed && ncons < 3) begin
        chk("release pc", o_pc, BOOT_ADDRESS + 32'(4 * ncons));
        ncons++;
      end
      seen_req = seen_req | o_req;
    end
    chk("release count", 32'(ncons), 32'd3);
    chk1("release resumes", seen_req, 1'b1);

    // Redirect with two requests in flight at 3-cycle latency.
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    lat   = 1;
    found = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_consumed && !found) begin
        found    = 1'b1;
        first_pc = o_pc;
      end
    end
    chk1("redir3 delivered", found, 1'b1);
    chk("redir3 first pc", first_pc, 32'h0000_0100);

    // Redirect colliding with a response and a decode pop.
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk1("collide pc_jump", o_jump, 1'b1);
    chk1("collide imem_req", o_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("collide flushed", o_valid, 1'b0);
    found = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_consumed && !found) begin
        found    = 1'b1;
        first_pc = o_pc;
      end
    end
    chk("collide first pc", first_pc, 32'h0000_0200);

    // Memory not accepting: address holds and the PC is not stepped.
    hold = pc_m;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("hold addr", o_addr, hold);
      chk1("hold wb", o_wb, 1'b0);
    end

    // Reset with queued and outstanding work, then restart from boot.
    lat = 4;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    lat   = 1;
    found = 1'b0;
    first_pc = '1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_consumed && !found) begin
        found    = 1'b1;
        first_pc = o_pc;
      end
    end
    chk("restart first pc", first_pc, BOOT_ADDRESS);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 24) == 0, $urandom() & 32'hFFFF_FFFC);
      if (i % 500 == 499) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
